ext_bus_arbiter: RTL and testbench
==================================

Name: ext_bus_arbiter

Overview:
- Shares one 16-bit external peripheral bus between the two Nios Avalon external-bus bridge masters (bridge 0, bridge 1).
- Sits in the DE1-SoC top level, between the nios_system bridge ports and the shared peripheral slave.
- Provides round-robin arbitration, registered slave-side signalling, a per-transaction timeout with error response, and IRQ routing back to the bridges.

Parameters:
- ADDR_W, 11: bridge/slave address width.
- DATA_W, 16: data width. byte_enable width is DATA_W/8.
- TIMEOUT_CYCLES, 255: slave cycles allowed before a forced response. Range 1..65535.
- ERR_DATA, 16'hDEAD: read data returned on timeout.
- IRQ_DEST, 2: s_irq routing. 0 = m0 only, 1 = m1 only, 2 = both.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_bus_enable  in  1  bridge 0 request, held until m0_acknowledge
- m0_rw  in  1  1 = read, 0 = write
- m0_address  in  ADDR_W  bridge 0 address
- m0_byte_enable  in  DATA_W/8  bridge 0 byte lanes
- m0_write_data  in  DATA_W  bridge 0 write data
- m0_acknowledge  out  1  one-cycle completion pulse
- m0_read_data  out  DATA_W  read data, valid with m0_acknowledge
- m0_irq  out  1  routed interrupt
- m1_*  same set as m0_*, for bridge 1
- s_bus_enable  out  1  request to slave
- s_rw, s_address, s_byte_enable, s_write_data  out  as m*  slave transaction fields
- s_acknowledge  in  1  slave completion
- s_read_data  in  DATA_W  slave read data
- s_irq  in  1  slave interrupt
- timeout_flag  out  1  sticky, set on any timeout, cleared only by reset
- owner  out  1  last/current granted master

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - All outputs go to 0: ack, read_data, s_* fields, s_bus_enable, timeout_flag.
  - owner resets to 1, so m0 wins the first tie.
  - Timeout counter cleared. State = IDLE.
- Reset mid-transaction aborts immediately:
  - No ack is issued to either master.
  - s_bus_enable goes low on the next cycle.
- FSM states: IDLE, BUSY, RESP, REST.
- IDLE:
  - Single request: grant that master.
  - Both m0_bus_enable and m1_bus_enable high: grant the master != owner (round robin).
  - On grant:
    - Register the winner's rw/address/byte_enable/write_data onto s_* and set s_bus_enable=1 at the next edge.
    - owner <= winner. Counter cleared. Go to BUSY.
  - Latency: request sampled in cycle N, s_bus_enable high in N+1.
- BUSY:
  - s_* held stable. The counter increments each cycle s_acknowledge=0.
  - s_acknowledge=1 in cycle M:
    - At the edge: capture s_read_data (all lanes; the master ignores it on writes).
    - Drop s_bus_enable; go to RESP.
  - Counter reaches TIMEOUT_CYCLES with s_acknowledge still 0:
    - Capture ERR_DATA instead, set timeout_flag, drop s_bus_enable, go to RESP.
  - s_acknowledge and timeout in the same cycle: the acknowledge wins, timeout_flag is not set.
- RESP (cycle M+1):
  - The owner's m*_acknowledge=1 for exactly one cycle, with m*_read_data valid.
  - The other master's ack stays 0. Go to REST.
- REST:
  - One idle cycle so the served bridge can drop bus_enable.
  - Requests are not sampled. Go to IDLE.
  - Minimum spacing between back-to-back transactions: 4 cycles plus slave wait states.
- m*_read_data holds its last captured value between responses.
- s_acknowledge outside BUSY is ignored.
- A master dropping bus_enable before its ack is a protocol violation; the arbiter still completes the transaction to the slave.
- Counter width is clog2(TIMEOUT_CYCLES+1) and it never wraps; it saturates at the compare value.
- IRQ: m0_irq/m1_irq are s_irq registered one cycle, gated per IRQ_DEST. Reset value 0.

Decomposition:
- Package ext_bus_pkg:
  - FSM state enum (IDLE, BUSY, RESP, REST).
  - Default ADDR_W/DATA_W constants.
  - ERR_DATA default.
  - Master-request struct (rw, address, byte_enable, write_data).
- Sub-module ext_bus_timeout:
  - Loadable saturating counter with clear, enable and expired output.
  - Parameterised by TIMEOUT_CYCLES.
- Everything else stays in ext_bus_arbiter.

Test Plan:
- Reset, then m0 read addr 11'h010; slave acks 2 cycles after s_bus_enable with 16'h1234 -> s_bus_enable rises 1 cycle after request; m0_acknowledge pulses 1 cycle after s_acknowledge with m0_read_data=16'h1234; m1_acknowledge stays 0.
- m0 and m1 assert in the same cycle after reset (m0 write 16'hAAAA to 11'h001, m1 write 16'h5555 to 11'h002) -> m0 served first, then m1 after REST; s_write_data/s_address match each in order; owner ends at 1.
- Both masters continuously requesting for 6 transactions -> grants strictly alternate 0,1,0,1,0,1; no ack ever goes to a master other than owner.
- TIMEOUT_CYCLES=8, slave never acks m1 read -> after 8 BUSY cycles m1_acknowledge pulses with 16'hDEAD; timeout_flag=1 and stays set through later good transactions until reset.
- Slave ack in the same cycle as timeout expiry -> real data returned, timeout_flag remains 0.
- Reset asserted during BUSY -> no acks issued, all outputs 0 the next cycle; s_irq pulse with IRQ_DEST=0 -> only m0_irq asserted, one cycle later.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// Shared types and defaults for the external bus arbiter.
// Bridge request bundle, FSM states, reset-time constants.
package ext_bus_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_REST = 2'd3
  } state_t;

  // Request fields at the default bus widths.
  typedef struct packed {
    logic                    rw;
    logic [ADDR_W_DEF-1:0]   address;
    logic [DATA_W_DEF/8-1:0] byte_enable;
    logic [DATA_W_DEF-1:0]   write_data;
  } bus_req_t;

endpackage

// File: rtl/ext_bus_timeout.sv
// Saturating slave-wait counter with clear, load and enable.
// o_expired flags the enabled cycle whose increment hits the limit.
module ext_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_load;

  assign w_load    = (i_load_val > LIMIT) ? LIMIT : i_load_val;
  assign o_expired = i_en && (r_cnt >= LAST);

  // Count enabled cycles, holding at the limit instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_load;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between two
// Avalon bridge masters, with slave timeout and IRQ fan-out.
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF),
  parameter int IRQ_DEST = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_bus_enable,
  input  logic                m0_rw,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byte_enable,
  input  logic [DATA_W-1:0]   m0_write_data,
  output logic                m0_acknowledge,
  output logic [DATA_W-1:0]   m0_read_data,
  output logic                m0_irq,
  input  logic                m1_bus_enable,
  input  logic                m1_rw,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byte_enable,
  input  logic [DATA_W-1:0]   m1_write_data,
  output logic                m1_acknowledge,
  output logic [DATA_W-1:0]   m1_read_data,
  output logic                m1_irq,
  output logic                s_bus_enable,
  output logic                s_rw,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byte_enable,
  output logic [DATA_W-1:0]   s_write_data,
  input  logic                s_acknowledge,
  input  logic [DATA_W-1:0]   s_read_data,
  input  logic                s_irq,
  output logic                timeout_flag,
  output logic                owner
);

  localparam int  BE_W   = DATA_W / 8;
  localparam logic IRQ_M0 = (IRQ_DEST != 1);
  localparam logic IRQ_M1 = (IRQ_DEST != 0);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byte_enable;
    logic [DATA_W-1:0] write_data;
  } req_t;

  state_t r_state;
  req_t   r_s;
  logic   r_sen;
  logic   r_owner;
  logic   r_ack0;
  logic   r_ack1;
  logic   r_tflag;
  logic   r_irq0;
  logic   r_irq1;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;

  req_t w_m0;
  req_t w_m1;
  req_t w_win;
  logic w_grant;
  logic w_pick;
  logic w_busy;
  logic w_cnt_en;
  logic w_expired;
  logic w_done;
  logic [DATA_W-1:0] w_cap;

  assign w_m0 = '{rw:          m0_rw,
                  address:     m0_address,
                  byte_enable: m0_byte_enable,
                  write_data:  m0_write_data};
  assign w_m1 = '{rw:          m1_rw,
                  address:     m1_address,
                  byte_enable: m1_byte_enable,
                  write_data:  m1_write_data};

  // On a tie the master that was not served last wins.
  assign w_pick  = (m0_bus_enable && m1_bus_enable) ?
                   ~r_owner : m1_bus_enable;
  assign w_win   = w_pick ? w_m1 : w_m0;
  assign w_grant = (r_state == ST_IDLE) &&
                   (m0_bus_enable || m1_bus_enable);

  assign w_busy   = (r_state == ST_BUSY);
  assign w_cnt_en = w_busy && !s_acknowledge;
  assign w_done   = w_busy && (s_acknowledge || w_expired);
  assign w_cap    = s_acknowledge ? s_read_data : ERR_DATA;

  ext_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_grant),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_cnt_en),
    .o_expired  (w_expired)
  );

  // Transaction sequencer: grant, wait for slave, respond, rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b1;
      r_s     <= '0;
      r_sen   <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_rd0   <= '0;
      r_rd1   <= '0;
      r_tflag <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_s     <= w_win;
            r_sen   <= 1'b1;
            r_owner <= w_pick;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_sen   <= 1'b0;
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_state <= ST_RESP;
            if (r_owner) r_rd1 <= w_cap;
            else         r_rd0 <= w_cap;
            if (w_expired) r_tflag <= 1'b1;
          end
        end
        ST_RESP: r_state <= ST_REST;
        ST_REST: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Slave interrupt delayed one cycle and steered to the bridges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq0 <= 1'b0;
      r_irq1 <= 1'b0;
    end else begin
      r_irq0 <= s_irq && IRQ_M0;
      r_irq1 <= s_irq && IRQ_M1;
    end
  end

  assign s_bus_enable   = r_sen;
  assign s_rw           = r_s.rw;
  assign s_address      = r_s.address;
  assign s_byte_enable  = r_s.byte_enable;
  assign s_write_data   = r_s.write_data;
  assign m0_acknowledge = r_ack0;
  assign m1_acknowledge = r_ack1;
  assign m0_read_data   = r_rd0;
  assign m1_read_data   = r_rd1;
  assign m0_irq         = r_irq0;
  assign m1_irq         = r_irq1;
  assign timeout_flag   = r_tflag;
  assign owner          = r_owner;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: bridge/slave BFMs plus a
// transaction-timeline model of grants, responses and IRQs.
module tb_ext_bus_arbiter;
  import ext_bus_pkg::*;

  localparam int T  = 8;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_bus_enable = 1'b0;
  logic          m0_rw = 1'b0;
  logic [AW-1:0] m0_address = '0;
  logic [BW-1:0] m0_byte_enable = '0;
  logic [DW-1:0] m0_write_data = '0;
  logic          m0_acknowledge;
  logic [DW-1:0] m0_read_data;
  logic          m0_irq;
  logic          m1_bus_enable = 1'b0;
  logic          m1_rw = 1'b0;
  logic [AW-1:0] m1_address = '0;
  logic [BW-1:0] m1_byte_enable = '0;
  logic [DW-1:0] m1_write_data = '0;
  logic          m1_acknowledge;
  logic [DW-1:0] m1_read_data;
  logic          m1_irq;
  logic          s_bus_enable;
  logic          s_rw;
  logic [AW-1:0] s_address;
  logic [BW-1:0] s_byte_enable;
  logic [DW-1:0] s_write_data;
  logic          s_acknowledge = 1'b0;
  logic [DW-1:0] s_read_data = '0;
  logic          s_irq = 1'b0;
  logic          timeout_flag;
  logic          owner;

  always #5 clk = ~clk;

  ext_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T),
    .ERR_DATA(16'hDEAD), .IRQ_DEST(0)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_bus_enable(m0_bus_enable), .m0_rw(m0_rw),
    .m0_address(m0_address), .m0_byte_enable(m0_byte_enable),
    .m0_write_data(m0_write_data),
    .m0_acknowledge(m0_acknowledge),
    .m0_read_data(m0_read_data), .m0_irq(m0_irq),
    .m1_bus_enable(m1_bus_enable), .m1_rw(m1_rw),
    .m1_address(m1_address), .m1_byte_enable(m1_byte_enable),
    .m1_write_data(m1_write_data),
    .m1_acknowledge(m1_acknowledge),
    .m1_read_data(m1_read_data), .m1_irq(m1_irq),
    .s_bus_enable(s_bus_enable), .s_rw(s_rw),
    .s_address(s_address), .s_byte_enable(s_byte_enable),
    .s_write_data(s_write_data),
    .s_acknowledge(s_acknowledge), .s_read_data(s_read_data),
    .s_irq(s_irq), .timeout_flag(timeout_flag), .owner(owner)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  bus_req_t q0[$];
  bus_req_t q1[$];
  int       lat_q[$];
  logic [DW-1:0] dat_q[$];
  bus_req_t cur[2];
  bit       pend[2];
  bit       done_now[2];
  bit       auto_gen = 0;
  bit       stray_en = 0;
  int       p_req = 40;

  bit       busy = 0;
  bit       who = 0;
  int       g_cyc = 0;
  int       g_lat = 0;
  int       resp_cyc = 0;
  bit       g_to = 0;
  bus_req_t g_req;
  logic [DW-1:0] g_data;
  bit       exp_owner = 1;
  bit       exp_flag = 0;
  int       m_free = 0;
  logic     prev_irq = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, act, exp);
    end
  endtask

  function automatic bus_req_t rnd_req();
    bus_req_t r;
    r.rw          = 1'($urandom);
    r.address     = AW'($urandom);
    r.byte_enable = BW'($urandom);
    r.write_data  = DW'($urandom);
    return r;
  endfunction

  function automatic bus_req_t mk(input bit rw,
                                  input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
    bus_req_t r;
    r.rw = rw;
    r.address = a;
    r.byte_enable = '1;
    r.write_data = d;
    return r;
  endfunction

  task automatic drive_masters();
    m0_bus_enable  = pend[0];
    m0_rw          = cur[0].rw;
    m0_address     = cur[0].address;
    m0_byte_enable = cur[0].byte_enable;
    m0_write_data  = cur[0].write_data;
    m1_bus_enable  = pend[1];
    m1_rw          = cur[1].rw;
    m1_address     = cur[1].address;
    m1_byte_enable = cur[1].byte_enable;
    m1_write_data  = cur[1].write_data;
  endtask

  task automatic step();
    bit inwin;
    @(posedge clk);
    #1;
    cyc++;
    chk("s_bus_enable", 32'(s_bus_enable),
        32'(busy && cyc > g_cyc && cyc < resp_cyc));
    chk("m0_ack", 32'(m0_acknowledge),
        32'(busy && cyc == resp_cyc && !who));
    chk("m1_ack", 32'(m1_acknowledge),
        32'(busy && cyc == resp_cyc && who));
    if (busy && cyc == g_cyc + 1) begin
      chk("s_rw", 32'(s_rw), 32'(g_req.rw));
      chk("s_address", 32'(s_address), 32'(g_req.address));
      chk("s_byte_enable", 32'(s_byte_enable),
          32'(g_req.byte_enable));
      chk("s_write_data", 32'(s_write_data),
          32'(g_req.write_data));
    end
    if (busy && cyc == resp_cyc) begin
      if (g_to) exp_flag = 1;
      chk(who ? "m1_read_data" : "m0_read_data",
          32'(who ? m1_read_data : m0_read_data),
          32'(g_to ? 16'hDEAD : g_data));
      pend[who] = 0;
      done_now[who] = 1;
      busy = 0;
      m_free = cyc + 2;
    end
    chk("owner", 32'(owner), 32'(exp_owner));
    chk("timeout_flag", 32'(timeout_flag), 32'(exp_flag));
    chk("m0_irq", 32'(m0_irq), 32'(prev_irq));
    chk("m1_irq", 32'(m1_irq), 32'(0));

    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && !done_now[i]) begin
        if (i == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front();
          pend[0] = 1;
        end else if (i == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front();
          pend[1] = 1;
        end else if (auto_gen && $urandom_range(99) < p_req) begin
          cur[i] = rnd_req();
          pend[i] = 1;
        end
      end
      if (!pend[i]) cur[i] = rnd_req();
      done_now[i] = 0;
    end

    inwin = busy && cyc > g_cyc && cyc < resp_cyc;
    s_acknowledge = 1'b0;
    s_read_data = DW'($urandom);
    if (inwin) begin
      if (!g_to && cyc == g_cyc + 1 + g_lat) begin
        s_acknowledge = 1'b1;
        s_read_data = g_data;
      end
    end else if (stray_en && $urandom_range(9) == 0) begin
      s_acknowledge = 1'b1;
    end
    s_irq = ($urandom_range(3) == 0);
    prev_irq = s_irq;
    drive_masters();

    if (!busy && cyc >= m_free && (pend[0] || pend[1])) begin
      who = (pend[0] && pend[1]) ? !exp_owner : pend[1];
      exp_owner = who;
      g_req = cur[who];
      g_cyc = cyc;
      if (lat_q.size() > 0) begin
        g_lat = lat_q.pop_front();
        g_data = dat_q.pop_front();
      end else begin
        g_lat = int'($urandom_range(12));
        g_data = DW'($urandom);
      end
      g_to = (g_lat >= T);
      resp_cyc = g_to ? cyc + T + 1 : cyc + g_lat + 2;
      busy = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend[0] = 0;
    pend[1] = 0;
    done_now[0] = 0;
    done_now[1] = 0;
    q0.delete();
    q1.delete();
    lat_q.delete();
    dat_q.delete();
    busy = 0;
    s_acknowledge = 1'b0;
    s_irq = 1'b0;
    drive_masters();
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_s_bus_enable", 32'(s_bus_enable), 32'(0));
      chk("rst_m0_ack", 32'(m0_acknowledge), 32'(0));
      chk("rst_m1_ack", 32'(m1_acknowledge), 32'(0));
      chk("rst_m0_rd", 32'(m0_read_data), 32'(0));
      chk("rst_m1_rd", 32'(m1_read_data), 32'(0));
      chk("rst_s_rw", 32'(s_rw), 32'(0));
      chk("rst_s_address", 32'(s_address), 32'(0));
      chk("rst_s_be", 32'(s_byte_enable), 32'(0));
      chk("rst_s_wdata", 32'(s_write_data), 32'(0));
      chk("rst_tflag", 32'(timeout_flag), 32'(0));
      chk("rst_m0_irq", 32'(m0_irq), 32'(0));
      chk("rst_m1_irq", 32'(m1_irq), 32'(0));
      chk("rst_owner", 32'(owner), 32'(1));
    end
    reset = 1'b0;
    exp_owner = 1;
    exp_flag = 0;
    m_free = cyc;
    prev_irq = 0;
    g_cyc = cyc;
    resp_cyc = cyc;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((busy || pend[0] || pend[1] ||
            q0.size() > 0 || q1.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n < maxc), 32'(1));
    repeat (3) step();
  endtask

  initial begin
    cur[0] = rnd_req();
    cur[1] = rnd_req();
    pend[0] = 0;
    pend[1] = 0;
    done_now[0] = 0;
    done_now[1] = 0;

    // Single read from bridge 0, slave waits two cycles.
    do_reset();
    q0.push_back(mk(1'b1, 11'h010, 16'h0000));
    lat_q.push_back(2);
    dat_q.push_back(16'h1234);
    drain(100);
    chk("m0_rd_hold", 32'(m0_read_data), 32'(16'h1234));

    // Simultaneous writes after reset: m0 first, then m1.
    do_reset();
    q0.push_back(mk(1'b0, 11'h001, 16'hAAAA));
    q1.push_back(mk(1'b0, 11'h002, 16'h5555));
    lat_q.push_back(1);
    dat_q.push_back(16'h0F0F);
    lat_q.push_back(0);
    dat_q.push_back(16'hF0F0);
    drain(100);
    chk("owner_end", 32'(owner), 32'(1));

    // Both bridges streaming: three requests each.
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'(i), AW'(11'h100 + i), DW'(16'hA000 + i)));
      q1.push_back(mk(1'(~i), AW'(11'h200 + i), DW'(16'hB000 + i)));
    end
    for (int i = 0; i < 6; i++) begin
      lat_q.push_back(i % 3);
      dat_q.push_back(DW'(16'hC000 + i));
    end
    drain(200);

    // Ack lands on the last allowed cycle: real data, no flag.
    do_reset();
    q0.push_back(mk(1'b1, 11'h033, 16'h0000));
    lat_q.push_back(T - 1);
    dat_q.push_back(16'h4321);
    drain(100);
    chk("tie_flag", 32'(timeout_flag), 32'(0));

    // Slave never answers m1: error data and sticky flag.
    q1.push_back(mk(1'b1, 11'h044, 16'h0000));
    lat_q.push_back(1000);
    dat_q.push_back(16'h0000);
    drain(100);
    chk("to_m1_rd", 32'(m1_read_data), 32'(16'hDEAD));
    q0.push_back(mk(1'b1, 11'h055, 16'h0000));
    q1.push_back(mk(1'b0, 11'h066, 16'h7777));
    lat_q.push_back(3);
    dat_q.push_back(16'h1111);
    lat_q.push_back(T);
    dat_q.push_back(16'h2222);
    drain(100);
    chk("flag_sticky", 32'(timeout_flag), 32'(1));

    // Reset while the slave is still busy.
    q0.push_back(mk(1'b1, 11'h077, 16'h0000));
    lat_q.push_back(1000);
    dat_q.push_back(16'h0000);
    begin
      int n = 0;
      while (!(busy && cyc >= g_cyc + 3) && n < 30) begin
        step();
        n++;
      end
      chk("busy_reached", 32'(n < 30), 32'(1));
    end
    do_reset();
    repeat (12) step();

    // Random traffic with stray acks and slave timeouts.
    auto_gen = 1;
    stray_en = 1;
    repeat (1500) step();
    auto_gen = 0;
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
